// File: rtl/lab54_mavg.sv
// Moving-average filter: ring-buffer window of DEPTH unsigned samples, running sum and mean.
// Build option LAB54_MAVG_ROUND_EN selects round-half-up for the mean instead of truncation.
module lab54_mavg #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned SUM_W = DATA_W + $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              dout_valid,
    output logic [DATA_W-1:0] dout,
    output logic [SUM_W-1:0]  sum,
    output logic              full
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);
`ifdef LAB54_MAVG_ROUND_EN
    localparam logic [SUM_W-1:0] RND_BIAS = SUM_W'(DEPTH / 2);
`else
    localparam logic [SUM_W-1:0] RND_BIAS = '0;
`endif

    logic [DATA_W-1:0] ring [DEPTH];
    logic [PTR_W-1:0]  wptr, wptr_n;
    logic [FILL_W-1:0] fill, fill_n;
    logic [SUM_W-1:0]  acc, acc_n;
    logic [SUM_W-1:0]  sum_n;
    logic [DATA_W-1:0] dout_n;
    logic              dout_valid_n;
    logic              full_n;
    logic              accept;

    // Next-state: oldest sample leaves the sum as the new one enters
    always_comb begin
        accept       = din_valid && !clr;
        wptr_n       = wptr;
        fill_n       = fill;
        acc_n        = acc;
        sum_n        = sum;
        dout_n       = dout;
        dout_valid_n = 1'b0;
        full_n       = full;
        if (accept) begin
            acc_n        = acc + SUM_W'(din) - SUM_W'(ring[wptr]);
            wptr_n       = wptr + PTR_W'(1);
            fill_n       = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
            sum_n        = acc_n;
            dout_n       = DATA_W'((acc_n + RND_BIAS) >> PTR_W);
            dout_valid_n = (fill_n == FILL_MAX);
            full_n       = (fill_n == FILL_MAX);
        end
    end

    // State and output registers; flush clears everything, including the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) ring[i] <= '0;
            wptr       <= '0;
            fill       <= '0;
            acc        <= '0;
            sum        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            full       <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < int'(DEPTH); i++) ring[i] <= '0;
            wptr       <= '0;
            fill       <= '0;
            acc        <= '0;
            sum        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            full       <= 1'b0;
        end else begin
            if (accept) ring[wptr] <= din;
            wptr       <= wptr_n;
            fill       <= fill_n;
            acc        <= acc_n;
            sum        <= sum_n;
            dout       <= dout_n;
            dout_valid <= dout_valid_n;
            full       <= full_n;
        end
    end

endmodule

// File: tb/tb_lab54_mavg.sv
// Scoreboard bench for lab54_mavg (DATA_W=8, DEPTH=4): driver queues expectations, monitor checks.
module tb_lab54_mavg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SUM_W  = 10;

    typedef struct {
        logic              dv;
        logic [SUM_W-1:0]  sum;
        logic [DATA_W-1:0] dout;
        logic              full;
        string             name;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              din_valid;
    logic [DATA_W-1:0] din;
    logic              dout_valid;
    logic [DATA_W-1:0] dout;
    logic [SUM_W-1:0]  sum;
    logic              full;

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    lab54_mavg #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .din_valid (din_valid),
        .din       (din),
        .dout_valid(dout_valid),
        .dout      (dout),
        .sum       (sum),
        .full      (full)
    );

    always #5 clk = ~clk;

    // Expected mean for a window sum of DEPTH=4 entries
    function automatic logic [DATA_W-1:0] mean4(input int s);
`ifdef LAB54_MAVG_ROUND_EN
        return DATA_W'((s + 2) / 4);
`else
        return DATA_W'(s / 4);
`endif
    endfunction

    function automatic exp_t mk(input string nm, input int s, input bit dv, input bit f);
        exp_t e;
        e.name = nm;
        e.sum  = SUM_W'(s);
        e.dout = mean4(s);
        e.dv   = dv;
        e.full = f;
        return e;
    endfunction

    task automatic check(input exp_t e);
        vectors++;
        if (dout_valid !== e.dv || sum !== e.sum || dout !== e.dout || full !== e.full) begin
            miscompares++;
            $display("FAIL %s: got dv=%0b sum=%0d dout=%0d full=%0b, want dv=%0b sum=%0d dout=%0d full=%0b",
                     e.name, dout_valid, sum, dout, full, e.dv, e.sum, e.dout, e.full);
        end
    endtask

    // One clocked transaction: inputs applied after the falling edge, result checked at the next one
    task automatic step(input bit v, input bit c, input int d, input exp_t e);
        @(negedge clk);
        #1;
        din_valid = v;
        clr       = c;
        din       = DATA_W'(d);
        sb_q.push_back(e);
    endtask

    task automatic send(input int d, input string nm, input int s, input bit dv, input bit f);
        step(1'b1, 1'b0, d, mk(nm, s, dv, f));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e);
            end
        end
    end

    initial begin : driver
        int waited;
        rst_n     = 1'b0;
        clr       = 1'b0;
        din_valid = 1'b1;
        din       = 8'hCB;
        repeat (3) @(posedge clk);
        #1;
        check(mk("reset_hold", 0, 1'b0, 1'b0));
        @(negedge clk);
        #1;
        rst_n     = 1'b1;
        din_valid = 1'b0;

        send(10, "fill1", 10, 1'b0, 1'b0);
        send(20, "fill2", 30, 1'b0, 1'b0);
        send(30, "fill3", 60, 1'b0, 1'b0);
        send(40, "fill4", 100, 1'b1, 1'b1);
        send(50, "slide50", 140, 1'b1, 1'b1);
        send(60, "wrap60", 180, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, mk("gap", 180, 1'b0, 1'b1));
        send(70, "resume70", 220, 1'b1, 1'b1);

        send(255, "max1", 435, 1'b1, 1'b1);
        send(255, "max2", 640, 1'b1, 1'b1);
        send(255, "max3", 835, 1'b1, 1'b1);
        send(255, "max4", 1020, 1'b1, 1'b1);
        step(1'b0, 1'b1, 0, mk("flush", 0, 1'b0, 1'b0));
        send(1, "rnd1", 1, 1'b0, 1'b0);
        send(1, "rnd2", 2, 1'b0, 1'b0);
        send(1, "rnd3", 3, 1'b0, 1'b0);
        send(0, "rnd4", 3, 1'b1, 1'b1);

        step(1'b1, 1'b1, 99, mk("flush_collide", 0, 1'b0, 1'b0));
        send(4, "post_clr1", 4, 1'b0, 1'b0);
        send(4, "post_clr2", 8, 1'b0, 1'b0);
        send(4, "post_clr3", 12, 1'b0, 1'b0);
        send(4, "post_clr4", 16, 1'b1, 1'b1);

        // Asynchronous reset pulsed entirely between two rising edges
        @(negedge clk);
        #1;
        din_valid = 1'b0;
        check(mk("pre_async", 16, 1'b1, 1'b1));
        #1;
        rst_n = 1'b0;
        #1;
        check(mk("async_clear", 0, 1'b0, 1'b0));
        #1;
        rst_n = 1'b1;

        step(1'b0, 1'b0, 0, mk("post_rst_idle", 0, 1'b0, 1'b0));
        send(5, "refill1", 5, 1'b0, 1'b0);
        send(5, "refill2", 10, 1'b0, 1'b0);
        send(5, "refill3", 15, 1'b0, 1'b0);
        send(5, "refill4", 20, 1'b1, 1'b1);
        step(1'b0, 1'b0, 0, mk("final_idle", 20, 1'b0, 1'b1));

        waited = 0;
        while (sb_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        #1;
        if (sb_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lab54_mavg.md
# lab54_mavg

Parametrised moving-average filter with valid qualification, ring-buffer window and synchronous flush. It is the next generation of the lab5 byte-stream datapath blocks. It takes a registered unsigned sample stream and produces the running window sum and the window mean. Width and window depth are generic, and output validity is gated on window fill. It sits directly behind the input register stage, and its outputs drive downstream logic or the bench monitor.

## Interface
- `DATA_W`, default 8: sample and mean width in bits (unsigned), legal range 2..32.
- `DEPTH`, default 8: window length in samples; a power of two, legal range 2..256.
- `SUM_W`: localparam equal to `DATA_W + $clog2(DEPTH)`; this is the window-sum width.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous flush of the window.
- `din_valid` in 1: `din` is accepted on this edge.
- `din` in `DATA_W`: input sample.
- `dout_valid` out 1: `dout` and `sum` describe a full window.
- `dout` out `DATA_W`: window mean.
- `sum` out `SUM_W`: window sum.
- `full` out 1: window holds `DEPTH` samples.

## Operation
- Storage is a ring buffer `buf[DEPTH]` of `DATA_W` registers plus the following state:
  - write pointer `wptr`, `$clog2(DEPTH)` bits;
  - fill counter `fill`, 0..`DEPTH`, saturating;
  - running sum `acc`, `SUM_W` bits.
- All arithmetic is unsigned. `acc` never overflows, because its maximum is `DEPTH*(2^DATA_W-1) < 2^SUM_W`.
- Accept happens when `din_valid=1` and `clr=0`. On accept:
  - `acc_n = acc + din - buf[wptr]`;
  - `buf[wptr] <= din`;
  - `wptr <= wptr+1`, wrapping `DEPTH-1 -> 0`;
  - `fill <= min(fill+1, DEPTH)`.
- Buffer entries are zero until written, so during fill `acc` is the exact partial sum.
- On accept, the outputs register as follows:
  - `sum <= acc_n`;
  - `dout <= acc_n >> log2(DEPTH)` (see Configuration);
  - `dout_valid <= (fill_n == DEPTH)`.
- During fill, `sum` and `dout` still update, but `dout_valid` stays 0.
- Idle is `din_valid=0`, `clr=0`:
  - `dout_valid <= 0`;
  - `sum`, `dout`, `full` and all internal state hold.
- Flush is `clr=1`. Its effects:
  - it has priority over `din_valid`, and a sample presented in the same cycle is dropped;
  - all `buf` entries, `wptr`, `fill`, `acc`, `sum`, `dout`, `dout_valid` and `full` go to 0 on that edge.
- `full` is a registered copy of `fill == DEPTH`. Once set, it stays 1 until `clr` or reset.
- Asynchronous reset (`rst_n=0`) forces the same all-zero state immediately, independent of `clk`. Reset asserted mid-stream discards the window, and no stale `dout_valid` follows release.

## Timing
- Latency: `sum`, `dout`, `dout_valid` and `full` are registered and reflect a sample accepted on edge N immediately after edge N.
- Throughput: one sample per clock.
- `dout_valid` is a one-cycle pulse per accepted sample once the window is full. It is continuously high under back-to-back `din_valid` after fill.
- The first `dout_valid` follows the `DEPTH`-th accepted sample since reset or the last `clr`.
- There is no combinational path from any input to any output.
- Reset value of every output is 0.

## Configuration
- Macro: `LAB54_MAVG_ROUND_EN`.
- When defined, `dout = (acc_n + DEPTH/2) >> log2(DEPTH)`, i.e. round half up.
  - The add is done in `SUM_W` bits and cannot overflow, because the maximum result is `2^DATA_W-1`.
- When not defined, `dout = acc_n >> log2(DEPTH)`, i.e. truncation.
- `sum` is identical in both builds.

## Test plan
All scenarios use `DATA_W=8`, `DEPTH=4`.
1. Reset: hold `rst_n=0` with `din_valid=1`, `din=0xCB` -> `dout`, `sum`, `dout_valid` and `full` are all 0. Release, then send 10, 20, 30, 40 back-to-back:
   - `dout_valid` is 0 after the first three samples;
   - after the fourth: `sum=100`, `dout=25`, `dout_valid=1`, `full=1`.
2. Slide and wrap: continue with 50 and 60 -> `sum=140`/`dout=35`, then `sum=180`/`dout=45`, with `dout_valid` high each cycle. This checks `wptr` wrap and oldest-sample subtraction.
3. Gaps: drop `din_valid` for 3 cycles mid-stream -> `dout_valid=0` in those cycles, while `sum`, `dout` and `full` hold. The next sample resumes the correct sum.
4. Extremes and rounding:
   - 255 x4 -> `sum=1020`, `dout=255` in both builds.
   - Then flush and send 1, 1, 1, 0 -> `sum=3`; `dout=0` without the macro, `dout=1` with `LAB54_MAVG_ROUND_EN`.
5. Flush collision: assert `clr=1` together with `din_valid=1`, `din=99` -> all outputs 0 and the sample is dropped. Then send 4, 4, 4, 4 -> `dout_valid` first high after the fourth sample, with `sum=16`, `dout=4`.
6. Async reset mid-stream: pulse `rst_n` low between clock edges while the window is full -> outputs clear immediately, without waiting for a clock edge. After release, the window refills from zero and needs 4 samples before `dout_valid`.
